multi_irqgen: RTL and testbench



---
 rtl/multi_irqgen.sv | 139 +++++++++++++
 tb/tb_multi_irqgen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_irqgen.sv
// Memory-mapped interrupt generator: staged mask/cause/delay/period, committed into a one-shot or periodic firing engine.
// Read data registered one cycle after req; grant is combinational and never stalls (no backpressure).
module multi_irqgen #(
   parameter int unsigned NumIrqs    = 4,
   parameter int unsigned CauseWidth = 8,
   parameter int unsigned CntWidth   = 32,
   parameter logic [31:0] BaseAddr   = 32'h2000
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  data_mem_req_i,
   input  logic                  data_mem_we_i,
   input  logic [31:0]           data_mem_addr_i,
   input  logic [31:0]           data_mem_wdata_i,
   input  logic [31:0]           data_mem_strb_i,
   output logic                  data_mem_gnt_o,
   output logic [31:0]           data_mem_rdata_o,
   output logic [NumIrqs-1:0]    irq_o,
   output logic [CauseWidth-1:0] cause_o
);

   typedef enum logic {IDLE, ARMED} state_t;

   state_t                state_q, state_nxt;
   logic [31:0]           off;
   logic [2:0]            idx;
   logic                  hit, wr;
   logic                  wr_mask, wr_cause, wr_delay, wr_period, commit, clr;
   logic                  fire;
   logic [31:0]           rd_val;

   logic [NumIrqs-1:0]    mask_q, act_mask;
   logic [CauseWidth-1:0] cause_q, act_cause;
   logic [CntWidth-1:0]   delay_q, period_q, act_period, cnt_q;
   logic [15:0]           fcnt_q;

   assign off            = data_mem_addr_i - BaseAddr;
   assign hit            = (data_mem_addr_i >= BaseAddr) && (off < 32'h38);
   assign data_mem_gnt_o = data_mem_req_i && hit;
   assign idx            = off[5:3];
   assign wr             = data_mem_gnt_o && data_mem_we_i;

   assign wr_mask   = wr && (idx == 3'd0);
   assign wr_cause  = wr && (idx == 3'd1);
   assign wr_delay  = wr && (idx == 3'd2);
   assign wr_period = wr && (idx == 3'd3);
   assign commit    = wr && (idx == 3'd4);
   assign clr       = wr && (idx == 3'd5);

   always_comb begin
      rd_val = '0;
      case (idx)
         3'd0:    rd_val = 32'(mask_q);
         3'd1:    rd_val = 32'(cause_q);
         3'd2:    rd_val = 32'(delay_q);
         3'd3:    rd_val = 32'(period_q);
         3'd6:    rd_val = {fcnt_q, 15'd0, state_q == ARMED};
         default: rd_val = '0;
      endcase
   end

   // A commit always wins: it cancels whatever fire would have happened this edge.
   always_comb begin
      state_nxt = state_q;
      fire      = 1'b0;
      if (commit) begin
         state_nxt = ARMED;
      end else if (state_q == ARMED && cnt_q == '0) begin
         fire = 1'b1;
         if (act_period == '0) state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_nxt;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mask_q   <= '0;
         cause_q  <= '0;
         delay_q  <= '0;
         period_q <= '0;
      end else begin
         if (wr_mask)
            mask_q <= (mask_q & ~data_mem_strb_i[NumIrqs-1:0])
                    | (data_mem_wdata_i[NumIrqs-1:0] & data_mem_strb_i[NumIrqs-1:0]);
         if (wr_cause)
            cause_q <= (cause_q & ~data_mem_strb_i[CauseWidth-1:0])
                     | (data_mem_wdata_i[CauseWidth-1:0] & data_mem_strb_i[CauseWidth-1:0]);
         if (wr_delay)
            delay_q <= (delay_q & ~data_mem_strb_i[CntWidth-1:0])
                     | (data_mem_wdata_i[CntWidth-1:0] & data_mem_strb_i[CntWidth-1:0]);
         if (wr_period)
            period_q <= (period_q & ~data_mem_strb_i[CntWidth-1:0])
                      | (data_mem_wdata_i[CntWidth-1:0] & data_mem_strb_i[CntWidth-1:0]);
      end
   end

   // Commit samples the staged registers before any same-cycle write lands.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         act_mask   <= '0;
         act_cause  <= '0;
         act_period <= '0;
         cnt_q      <= '0;
         fcnt_q     <= '0;
      end else if (commit) begin
         act_mask   <= mask_q;
         act_cause  <= cause_q;
         act_period <= period_q;
         cnt_q      <= delay_q;
         fcnt_q     <= '0;
      end else if (state_q == ARMED) begin
         if (cnt_q != '0) cnt_q <= cnt_q - CntWidth'(1);
         else if (act_period != '0) cnt_q <= act_period - CntWidth'(1);
         if (fire && fcnt_q != 16'hFFFF) fcnt_q <= fcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_o   <= '0;
         cause_o <= '0;
      end else begin
         irq_o <= (irq_o & ~(clr ? (data_mem_wdata_i[NumIrqs-1:0] & data_mem_strb_i[NumIrqs-1:0])
                                 : {NumIrqs{1'b0}}))
                | (fire ? act_mask : {NumIrqs{1'b0}});
         if (fire) cause_o <= act_cause;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             data_mem_rdata_o <= '0;
      else if (data_mem_req_i) data_mem_rdata_o <= (hit && !data_mem_we_i) ? rd_val : '0;
   end

endmodule

// File: tb/tb_multi_irqgen.sv
// Bench for multi_irqgen: directed scenarios plus random bus traffic against an edge-indexed reference model.
module tb_multi_irqgen;

   localparam logic [31:0] BASE   = 32'h2000;
   localparam logic [31:0] MASKM  = 32'h0000_000F;
   localparam logic [31:0] CAUSEM = 32'h0000_00FF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we;
   logic [31:0] addr, wdata, strb;
   logic        gnt;
   logic [31:0] rdata;
   logic [3:0]  irq;
   logic [7:0]  cause;

   int n_chk = 0;
   int n_bad = 0;

   multi_irqgen #(.NumIrqs(4), .CauseWidth(8), .CntWidth(32), .BaseAddr(BASE)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .data_mem_req_i(req), .data_mem_we_i(we), .data_mem_addr_i(addr),
      .data_mem_wdata_i(wdata), .data_mem_strb_i(strb),
      .data_mem_gnt_o(gnt), .data_mem_rdata_o(rdata),
      .irq_o(irq), .cause_o(cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: fires are derived from the commit edge index, delay and period.
   logic [31:0] m_mask, m_cause, m_delay, m_period;
   logic [31:0] a_mask, a_cause, a_delay, a_period;
   logic [31:0] m_irq, m_cs, m_fc, m_rd;
   bit          m_comm;
   longint      m_n, m_ce;

   task automatic model_reset();
      m_mask = 0; m_cause = 0; m_delay = 0; m_period = 0;
      a_mask = 0; a_cause = 0; a_delay = 0; a_period = 0;
      m_irq = 0; m_cs = 0; m_fc = 0; m_rd = 0;
      m_comm = 0; m_n = 0; m_ce = 0;
   endtask

   function automatic bit m_hit(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < 32'h38);
   endfunction

   function automatic bit m_armed();
      if (!m_comm) return 1'b0;
      if (a_period != 0) return 1'b1;
      return m_n <= m_ce + longint'(a_delay) + 1;
   endfunction

   function automatic bit m_due();
      longint k;
      k = m_n - m_ce - longint'(a_delay) - 1;
      if (k < 0) return 1'b0;
      return (k == 0) || (a_period != 0 && (k % longint'(a_period)) == 0);
   endfunction

   task automatic model_edge(input logic r, input logic w_en, input logic [31:0] a, w, s);
      bit          hit, commit, fire;
      int          idx;
      logic [31:0] rdv;
      m_n++;
      hit    = r && m_hit(a);
      idx    = int'((a - BASE) >> 3);
      commit = hit && w_en && idx == 4;
      fire   = m_armed() && m_due() && !commit;
      rdv    = 0;
      if (hit && !w_en) begin
         case (idx)
            0: rdv = m_mask;
            1: rdv = m_cause;
            2: rdv = m_delay;
            3: rdv = m_period;
            6: rdv = {m_fc[15:0], 15'd0, m_armed()};
            default: rdv = 0;
         endcase
      end
      if (hit && w_en && idx == 5) m_irq = m_irq & ~(w & s & MASKM);
      if (fire) begin
         m_irq = m_irq | a_mask;
         m_cs  = a_cause;
         if (m_fc != 32'hFFFF) m_fc = m_fc + 1;
      end
      if (commit) begin
         a_mask = m_mask; a_cause = m_cause; a_delay = m_delay; a_period = m_period;
         m_ce = m_n; m_comm = 1; m_fc = 0;
      end
      if (hit && w_en) begin
         case (idx)
            0: m_mask   = ((m_mask & ~s) | (w & s)) & MASKM;
            1: m_cause  = ((m_cause & ~s) | (w & s)) & CAUSEM;
            2: m_delay  = (m_delay & ~s) | (w & s);
            3: m_period = (m_period & ~s) | (w & s);
            default: ;
         endcase
      end
      if (r) m_rd = rdv;
   endtask

   // One bus cycle: drive at negedge, check grant, clock, then check outputs.
   task automatic cyc(input logic r, input logic w_en, input logic [31:0] a, w, s);
      req = r; we = w_en; addr = a; wdata = w; strb = s;
      #1;
      chk("gnt", 32'(gnt), 32'(r && m_hit(a)));
      @(posedge clk);
      model_edge(r, w_en, a, w, s);
      #1;
      chk("irq", 32'(irq), m_irq);
      chk("cause", 32'(cause), m_cs);
      chk("rdata", rdata, m_rd);
      @(negedge clk);
      req = 0; we = 0;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      cyc(1'b1, 1'b1, BASE + off, d, 32'hFFFF_FFFF);
   endtask

   task automatic rd(input logic [31:0] off);
      cyc(1'b1, 1'b0, BASE + off, 32'h0, 32'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; req = 0; we = 0; addr = 0; wdata = 0; strb = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_cause", 32'(cause), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         rd(32'(i * 8));
         chk("rst_reg", rdata, 32'h0);
      end

      // One-shot
      wr(32'h00, 32'h5); wr(32'h08, 32'h2A); wr(32'h10, 32'd3); wr(32'h18, 32'd0);
      wr(32'h20, 32'h1);
      idle(3);
      chk("os_early", 32'(irq), 32'h0);
      idle(1);
      chk("os_irq", 32'(irq), 32'h5);
      chk("os_cause", 32'(cause), 32'h2A);
      rd(32'h30);
      chk("os_status", rdata, 32'h0001_0000);
      wr(32'h28, 32'hF);

      // Periodic with clear after each fire
      wr(32'h00, 32'h1); wr(32'h10, 32'd0); wr(32'h18, 32'd2);
      wr(32'h20, 32'h1);
      idle(1);         chk("per_f1", 32'(irq), 32'h1);
      wr(32'h28, 32'h1); chk("per_c1", 32'(irq), 32'h0);
      idle(1);         chk("per_f2", 32'(irq), 32'h1);
      wr(32'h28, 32'h1);
      idle(1);         chk("per_f3", 32'(irq), 32'h1);
      rd(32'h30);
      chk("per_status", rdata, 32'h0003_0001);

      // Clear on the exact fire edge
      wr(32'h00, 32'h3);
      wr(32'h20, 32'h1);
      idle(1);
      wr(32'h28, 32'h3); chk("col_clr", 32'(irq), 32'h0);
      wr(32'h28, 32'h3); chk("col_fire", 32'(irq), 32'h3);

      // Restart while armed
      wr(32'h00, 32'h8); wr(32'h18, 32'd0); wr(32'h10, 32'd10);
      wr(32'h20, 32'h1);
      wr(32'h28, 32'hF);
      idle(2);
      wr(32'h10, 32'd1);
      wr(32'h20, 32'h1);
      idle(1); chk("rs_early", 32'(irq), 32'h0);
      idle(1); chk("rs_fire", 32'(irq), 32'h8);
      wr(32'h28, 32'hF);
      idle(6); chk("rs_orig", 32'(irq), 32'h0);
      rd(32'h30);
      chk("rs_status", rdata, 32'h0001_0000);

      // Strobe and miss
      wr(32'h08, 32'h0);
      cyc(1'b1, 1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 32'h0000_000F);
      rd(32'h08);
      chk("strb_cause", rdata, 32'h0F);
      cyc(1'b1, 1'b1, BASE + 32'h38, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cyc(1'b1, 1'b0, BASE + 32'h38, 32'h0, 32'h0);
      chk("miss_rdata", rdata, 32'h0);
      rd(32'h08);
      chk("miss_nochg", rdata, 32'h0F);

      // Reset mid-count aborts without firing
      wr(32'h00, 32'hF); wr(32'h10, 32'd5); wr(32'h20, 32'h1);
      idle(2);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_irq", 32'(irq), 32'h0);
      chk("mid_rst_rdata", rdata, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(8);
      chk("mid_rst_nofire", 32'(irq), 32'h0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         int          op;
         logic [31:0] s;
         op = int'($urandom_range(0, 11));
         s  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
         case (op)
            0: cyc(1'b1, 1'b1, BASE + 32'h00, $urandom, s);
            1: cyc(1'b1, 1'b1, BASE + 32'h08, $urandom, s);
            2: wr(32'h10, $urandom_range(0, 6));
            3: wr(32'h18, $urandom_range(0, 4));
            4: wr(32'h20, $urandom);
            5: cyc(1'b1, 1'b1, BASE + 32'h28, $urandom, s);
            6: cyc(1'b1, 1'b0, BASE + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7)),
                   32'h0, 32'h0);
            7: cyc(1'b1, 1'($urandom_range(0, 1)), BASE - 32'h8 + 32'($urandom_range(0, 79)),
                   $urandom, s);
            default: idle(1);
         endcase
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
